// File: rtl/prefetch_issue_arbiter.sv
// Prefetch issue arbiter: dedups prefetch candidates into a small FIFO and shares the
// single lower-level request port between demand misses and queued prefetches.
module prefetch_issue_arbiter #(
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned QUEUE_DEPTH  = 8,
  parameter int unsigned BLOCK_OFFSET = 6,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WIDTH-1:0]               pf_addr_i,
  input  logic                           pf_valid_i,
  output logic                           pf_ready_o,
  input  logic [WIDTH-1:0]               dm_addr_i,
  input  logic                           dm_valid_i,
  output logic                           dm_ready_o,
  output logic [WIDTH-1:0]               lo_addr_o,
  output logic                           lo_valid_o,
  output logic                           lo_is_prefetch_o,
  input  logic                           lo_ready_i,
  output logic [15:0]                    drop_count_o,
  output logic [$clog2(QUEUE_DEPTH):0]   q_count_o
);

  localparam int unsigned PW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned NW = CW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned DW = 16;
  localparam logic [WIDTH-1:0] BLK_MASK = ~((WIDTH'(1) << BLOCK_OFFSET) - WIDTH'(1));

  typedef enum logic [1:0] {EMPTY, HOLD_DM, HOLD_PF} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       q_addr [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] q_valid, q_valid_d, q_live, q_live_d, sq;
  logic [PW-1:0]          head_q, tail_q;
  logic [CW-1:0]          count_q, count_d;
  logic [SW-1:0]          starve_q, starve_d;
  logic [DW-1:0]          drop_q, drop_d;
  logic [DW:0]            drop_sum;
  logic [NW-1:0]          n_drop;
  logic [WIDTH-1:0]       lo_addr_q, lo_addr_d;
  logic                   lo_valid_q, lo_valid_d, lo_pf_q, lo_pf_d, pf_ready_q;
  logic [WIDTH-1:0]       pf_blk, dm_blk;
  logic                   head_live, head_dead, any_live, slot_free, force_pf;
  logic                   pf_grant, dm_grant, dup, push, pop, pf_take;

  assign pf_blk    = pf_addr_i & BLK_MASK;
  assign dm_blk    = dm_addr_i & BLK_MASK;
  assign head_live = q_valid[head_q] & q_live[head_q];
  assign head_dead = q_valid[head_q] & ~q_live[head_q];
  assign any_live  = |(q_valid & q_live);
  assign force_pf  = (starve_q == SW'(STARVE_LIMIT)) & head_live;

  // Output slot FSM: decides what, if anything, loads into the request slot
  always_comb begin
    state_d    = state_q;
    lo_addr_d  = lo_addr_q;
    lo_valid_d = lo_valid_q;
    lo_pf_d    = lo_pf_q;
    pf_grant   = 1'b0;
    dm_grant   = 1'b0;
    case (state_q)
      EMPTY:            slot_free = 1'b1;
      HOLD_DM, HOLD_PF: slot_free = lo_valid_q & lo_ready_i;
      default:          slot_free = 1'b1;
    endcase
    if (slot_free) begin
      if (force_pf || (!dm_valid_i && head_live)) begin
        pf_grant   = 1'b1;
        lo_addr_d  = q_addr[head_q];
        lo_valid_d = 1'b1;
        lo_pf_d    = 1'b1;
        state_d    = HOLD_PF;
      end else if (dm_valid_i) begin
        dm_grant   = 1'b1;
        lo_addr_d  = dm_addr_i;
        lo_valid_d = 1'b1;
        lo_pf_d    = 1'b0;
        state_d    = HOLD_DM;
      end else begin
        lo_valid_d = 1'b0;
        lo_pf_d    = 1'b0;
        state_d    = EMPTY;
      end
    end
  end

  // Demand handshake is combinational; held low while reset is asserted
  assign dm_ready_o = rst & dm_grant;

  // Queue bookkeeping: dedup, squash, push/pop and the drop counter
  always_comb begin
    sq  = '0;
    dup = (lo_valid_q && ((lo_addr_q & BLK_MASK) == pf_blk)) || (dm_grant && (dm_blk == pf_blk));
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (q_valid[i] && q_live[i] && (q_addr[i] == pf_blk)) dup = 1'b1;
      sq[i] = dm_grant & q_valid[i] & q_live[i] & (q_addr[i] == dm_blk);
    end
    pf_take = pf_valid_i & pf_ready_q;
    push    = pf_take & ~dup;
    pop     = pf_grant | head_dead;

    q_valid_d = q_valid;
    q_live_d  = q_live & ~sq;
    if (pop) begin
      q_valid_d[head_q] = 1'b0;
      q_live_d[head_q]  = 1'b0;
    end
    if (push) begin
      q_valid_d[tail_q] = 1'b1;
      q_live_d[tail_q]  = 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);

    n_drop = NW'(pf_take & dup);
    for (int i = 0; i < QUEUE_DEPTH; i++) n_drop = n_drop + NW'(sq[i]);
    drop_sum = {1'b0, drop_q} + (DW + 1)'(n_drop);
    drop_d   = drop_sum[DW] ? '1 : drop_sum[DW-1:0];

    starve_d = starve_q;
    if (pf_grant) starve_d = '0;
    else if (dm_grant && head_live)
      starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
    else if (!any_live) starve_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      q_valid    <= '0;
      q_live     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      drop_q     <= '0;
      lo_addr_q  <= '0;
      lo_valid_q <= 1'b0;
      lo_pf_q    <= 1'b0;
      pf_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_valid    <= q_valid_d;
      q_live     <= q_live_d;
      head_q     <= pop ? head_q + PW'(1) : head_q;
      tail_q     <= push ? tail_q + PW'(1) : tail_q;
      count_q    <= count_d;
      starve_q   <= starve_d;
      drop_q     <= drop_d;
      lo_addr_q  <= lo_addr_d;
      lo_valid_q <= lo_valid_d;
      lo_pf_q    <= lo_pf_d;
      pf_ready_q <= (count_d < CW'(QUEUE_DEPTH));
    end
  end

  // Entry payload storage needs no reset; validity is tracked by q_valid
  always_ff @(posedge clk) begin
    if (push) q_addr[tail_q] <= pf_blk;
  end

  assign pf_ready_o       = pf_ready_q;
  assign lo_addr_o        = lo_addr_q;
  assign lo_valid_o       = lo_valid_q;
  assign lo_is_prefetch_o = lo_pf_q;
  assign drop_count_o     = drop_q;
  assign q_count_o        = count_q;

endmodule

// File: tb/tb_prefetch_issue_arbiter.sv
// Directed bench for prefetch_issue_arbiter; inputs change and outputs are sampled on
// the falling clock edge.
module tb_prefetch_issue_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pf_addr_i, dm_addr_i;
  logic        pf_valid_i, dm_valid_i, lo_ready_i;
  logic        pf_ready_o, dm_ready_o, lo_valid_o, lo_is_prefetch_o;
  logic [63:0] lo_addr_o;
  logic [15:0] drop_count_o;
  logic [3:0]  q_count_o;

  int n_vec = 0;
  int n_err = 0;

  prefetch_issue_arbiter dut (
    .clk(clk), .rst(rst),
    .pf_addr_i(pf_addr_i), .pf_valid_i(pf_valid_i), .pf_ready_o(pf_ready_o),
    .dm_addr_i(dm_addr_i), .dm_valid_i(dm_valid_i), .dm_ready_o(dm_ready_o),
    .lo_addr_o(lo_addr_o), .lo_valid_o(lo_valid_o), .lo_is_prefetch_o(lo_is_prefetch_o),
    .lo_ready_i(lo_ready_i), .drop_count_o(drop_count_o), .q_count_o(q_count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic idle_inputs();
    pf_addr_i = '0; pf_valid_i = 1'b0;
    dm_addr_i = '0; dm_valid_i = 1'b0;
    lo_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    dm_valid_i = 1'b1; dm_addr_i = 64'h1234;
    @(negedge clk); #1;
    n_vec++; if (lo_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_lo_valid: got %b want 0", lo_valid_o); end
    n_vec++; if (q_count_o !== 4'd0) begin n_err++; $display("FAIL rst_q_count: got %0d want 0", q_count_o); end
    n_vec++; if (drop_count_o !== 16'd0) begin n_err++; $display("FAIL rst_drop: got %0d want 0", drop_count_o); end
    n_vec++; if (pf_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_pf_ready: got %b want 0", pf_ready_o); end
    n_vec++; if (dm_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_dm_ready: got %b want 0", dm_ready_o); end
    dm_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (pf_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_release_pf_ready: got %b want 1", pf_ready_o); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    pf_valid_i = 1'b1; pf_addr_i = 64'h6000;
    @(negedge clk); pf_addr_i = 64'h6040;
    @(negedge clk); pf_addr_i = 64'h6080;
    @(negedge clk); pf_addr_i = 64'h60C0;
    @(negedge clk); pf_valid_i = 1'b0;
    n_vec++; if (q_count_o !== 4'd3) begin n_err++; $display("FAIL midop_q_count: got %0d want 3", q_count_o); end
    n_vec++; if (lo_addr_o !== 64'h6000 || lo_is_prefetch_o !== 1'b1 || lo_valid_o !== 1'b1) begin
      n_err++; $display("FAIL midop_hold_pf: got %h/%b/%b want 6000/1/1", lo_addr_o, lo_is_prefetch_o, lo_valid_o); end
    #2 rst = 1'b0;
    #1;
    n_vec++; if (lo_valid_o !== 1'b0) begin n_err++; $display("FAIL midop_rst_lo_valid: got %b want 0", lo_valid_o); end
    n_vec++; if (q_count_o !== 4'd0) begin n_err++; $display("FAIL midop_rst_q_count: got %0d want 0", q_count_o); end
    n_vec++; if (drop_count_o !== 16'd0) begin n_err++; $display("FAIL midop_rst_drop: got %0d want 0", drop_count_o); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    n_vec++; if (pf_ready_o !== 1'b1) begin n_err++; $display("FAIL midop_release_pf_ready: got %b want 1", pf_ready_o); end
    n_vec++; if (lo_valid_o !== 1'b0) begin n_err++; $display("FAIL midop_release_lo_valid: got %b want 0", lo_valid_o); end
  endtask

  task automatic test_dedup();
    do_reset();
    pf_valid_i = 1'b1; pf_addr_i = 64'h1000;
    @(negedge clk); pf_addr_i = 64'h1008;
    @(negedge clk); pf_addr_i = 64'h2000;
    @(negedge clk); pf_valid_i = 1'b0;
    n_vec++; if (drop_count_o !== 16'd1) begin n_err++; $display("FAIL dedup_drop: got %0d want 1", drop_count_o); end
    n_vec++; if (q_count_o !== 4'd1) begin n_err++; $display("FAIL dedup_q_count: got %0d want 1", q_count_o); end
    n_vec++; if (lo_addr_o !== 64'h1000 || lo_is_prefetch_o !== 1'b1 || lo_valid_o !== 1'b1) begin
      n_err++; $display("FAIL dedup_first: got %h/%b/%b want 1000/1/1", lo_addr_o, lo_is_prefetch_o, lo_valid_o); end
    lo_ready_i = 1'b1;
    @(negedge clk);
    n_vec++; if (lo_addr_o !== 64'h2000 || lo_is_prefetch_o !== 1'b1 || lo_valid_o !== 1'b1) begin
      n_err++; $display("FAIL dedup_second: got %h/%b/%b want 2000/1/1", lo_addr_o, lo_is_prefetch_o, lo_valid_o); end
    n_vec++; if (q_count_o !== 4'd0) begin n_err++; $display("FAIL dedup_q_empty: got %0d want 0", q_count_o); end
    @(negedge clk);
    n_vec++; if (lo_valid_o !== 1'b0) begin n_err++; $display("FAIL dedup_idle: got %b want 0", lo_valid_o); end
    lo_ready_i = 1'b0;
  endtask

  task automatic test_starvation();
    logic [63:0] exp_a;
    do_reset();
    dm_valid_i = 1'b1; dm_addr_i = 64'h9000;
    #1;
    n_vec++; if (dm_ready_o !== 1'b1) begin n_err++; $display("FAIL starve_first_dm_ready: got %b want 1", dm_ready_o); end
    @(negedge clk); dm_valid_i = 1'b0; pf_valid_i = 1'b1; pf_addr_i = 64'h3000;
    @(negedge clk); pf_valid_i = 1'b0;
    n_vec++; if (q_count_o !== 4'd1 || lo_addr_o !== 64'h9000) begin
      n_err++; $display("FAIL starve_setup: got q=%0d addr=%h want q=1 addr=9000", q_count_o, lo_addr_o); end
    lo_ready_i = 1'b1; dm_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_a = 64'hA000 + 64'(i) * 64'h40;
      dm_addr_i = exp_a;
      #1;
      n_vec++; if (dm_ready_o !== 1'b1) begin n_err++; $display("FAIL starve_dm_ready_%0d: got %b want 1", i, dm_ready_o); end
      @(negedge clk);
      n_vec++; if (lo_addr_o !== exp_a || lo_is_prefetch_o !== 1'b0) begin
        n_err++; $display("FAIL starve_dm_%0d: got %h/%b want %h/0", i, lo_addr_o, lo_is_prefetch_o, exp_a); end
    end
    dm_addr_i = 64'hA100;
    #1;
    n_vec++; if (dm_ready_o !== 1'b0) begin n_err++; $display("FAIL starve_forced_dm_ready: got %b want 0", dm_ready_o); end
    @(negedge clk);
    n_vec++; if (lo_addr_o !== 64'h3000 || lo_is_prefetch_o !== 1'b1) begin
      n_err++; $display("FAIL starve_pf_issue: got %h/%b want 3000/1", lo_addr_o, lo_is_prefetch_o); end
    #1;
    n_vec++; if (dm_ready_o !== 1'b1) begin n_err++; $display("FAIL starve_resume_ready: got %b want 1", dm_ready_o); end
    @(negedge clk);
    n_vec++; if (lo_addr_o !== 64'hA100 || lo_is_prefetch_o !== 1'b0) begin
      n_err++; $display("FAIL starve_resume: got %h/%b want a100/0", lo_addr_o, lo_is_prefetch_o); end
    dm_valid_i = 1'b0; lo_ready_i = 1'b0;
  endtask

  task automatic test_squash();
    do_reset();
    dm_valid_i = 1'b1; dm_addr_i = 64'h8000;
    @(negedge clk); dm_valid_i = 1'b0; pf_valid_i = 1'b1; pf_addr_i = 64'h4000;
    @(negedge clk); pf_addr_i = 64'h5000;
    @(negedge clk); pf_valid_i = 1'b0;
    n_vec++; if (q_count_o !== 4'd2) begin n_err++; $display("FAIL squash_setup_q: got %0d want 2", q_count_o); end
    lo_ready_i = 1'b1; dm_valid_i = 1'b1; dm_addr_i = 64'h4010;
    #1;
    n_vec++; if (dm_ready_o !== 1'b1) begin n_err++; $display("FAIL squash_dm_ready: got %b want 1", dm_ready_o); end
    @(negedge clk); dm_valid_i = 1'b0;
    n_vec++; if (lo_addr_o !== 64'h4010 || lo_is_prefetch_o !== 1'b0) begin
      n_err++; $display("FAIL squash_dm_issue: got %h/%b want 4010/0", lo_addr_o, lo_is_prefetch_o); end
    n_vec++; if (drop_count_o !== 16'd1) begin n_err++; $display("FAIL squash_drop: got %0d want 1", drop_count_o); end
    @(negedge clk);
    n_vec++; if (q_count_o !== 4'd1 || lo_valid_o !== 1'b0) begin
      n_err++; $display("FAIL squash_dead_pop: got q=%0d valid=%b want q=1 valid=0", q_count_o, lo_valid_o); end
    @(negedge clk);
    n_vec++; if (lo_addr_o !== 64'h5000 || lo_is_prefetch_o !== 1'b1 || lo_valid_o !== 1'b1) begin
      n_err++; $display("FAIL squash_next_pf: got %h/%b/%b want 5000/1/1", lo_addr_o, lo_is_prefetch_o, lo_valid_o); end
    n_vec++; if (q_count_o !== 4'd0 || drop_count_o !== 16'd1) begin
      n_err++; $display("FAIL squash_final: got q=%0d drop=%0d want q=0 drop=1", q_count_o, drop_count_o); end
    lo_ready_i = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    dm_valid_i = 1'b1; dm_addr_i = 64'h9000;
    @(negedge clk); dm_valid_i = 1'b0; pf_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pf_addr_i = 64'hB000 + 64'(i) * 64'h40;
      n_vec++; if (pf_ready_o !== 1'b1) begin n_err++; $display("FAIL full_ready_%0d: got %b want 1", i, pf_ready_o); end
      @(negedge clk);
    end
    pf_addr_i = 64'hC000;
    n_vec++; if (pf_ready_o !== 1'b0 || q_count_o !== 4'd8) begin
      n_err++; $display("FAIL full_reached: got ready=%b q=%0d want ready=0 q=8", pf_ready_o, q_count_o); end
    @(negedge clk);
    n_vec++; if (q_count_o !== 4'd8 || drop_count_o !== 16'd0) begin
      n_err++; $display("FAIL full_ninth: got q=%0d drop=%0d want q=8 drop=0", q_count_o, drop_count_o); end
    lo_ready_i = 1'b1;
    @(negedge clk); lo_ready_i = 1'b0;
    n_vec++; if (pf_ready_o !== 1'b1 || q_count_o !== 4'd7 || lo_addr_o !== 64'hB000) begin
      n_err++; $display("FAIL full_pop: got ready=%b q=%0d addr=%h want 1/7/b000", pf_ready_o, q_count_o, lo_addr_o); end
    @(negedge clk); pf_valid_i = 1'b0;
    n_vec++; if (q_count_o !== 4'd8 || pf_ready_o !== 1'b0) begin
      n_err++; $display("FAIL full_refill: got q=%0d ready=%b want 8/0", q_count_o, pf_ready_o); end
  endtask

  task automatic test_hold();
    do_reset();
    dm_valid_i = 1'b1; dm_addr_i = 64'h7000;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      dm_valid_i = i[0]; dm_addr_i = 64'h7100 + 64'(i) * 64'h40;
      pf_valid_i = ~i[0]; pf_addr_i = 64'hD000 + 64'(i) * 64'h40;
      #1;
      n_vec++; if (dm_ready_o !== 1'b0) begin n_err++; $display("FAIL hold_dm_ready_%0d: got %b want 0", i, dm_ready_o); end
      n_vec++; if (lo_addr_o !== 64'h7000 || lo_is_prefetch_o !== 1'b0 || lo_valid_o !== 1'b1) begin
        n_err++; $display("FAIL hold_stable_%0d: got %h/%b/%b want 7000/0/1", i, lo_addr_o, lo_is_prefetch_o, lo_valid_o); end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_dedup();
    test_starvation();
    test_squash();
    test_full();
    test_hold();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prefetch_issue_arbiter.md
Name: prefetch_issue_arbiter

Overview:
Sits between the bingo prefetcher and the lower-level cache request port. It buffers prefetch candidates in a small FIFO and drops duplicate block addresses. It arbitrates the single lower-level port between demand misses and queued prefetches: demand has priority, and a starvation limit guarantees that prefetches make forward progress.

Parameters:
WIDTH, 64, address width in bits.
QUEUE_DEPTH, 8, prefetch FIFO entries; must be a power of 2 and at least 2.
BLOCK_OFFSET, 6, log2 of the cache block size in bytes; low bits cleared for block alignment.
STARVE_LIMIT, 4, consecutive demand grants allowed while the queue holds a live entry before a prefetch is forced.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-low reset.
pf_addr_i  in  WIDTH  prefetch candidate address from the prefetcher.
pf_valid_i  in  1  prefetch candidate valid.
pf_ready_o  out  1  queue can accept a candidate.
dm_addr_i  in  WIDTH  demand miss address.
dm_valid_i  in  1  demand request valid.
dm_ready_o  out  1  demand request accepted this cycle.
lo_addr_o  out  WIDTH  request address to the lower-level cache.
lo_valid_o  out  1  request valid.
lo_is_prefetch_o  out  1  1 = prefetch, 0 = demand.
lo_ready_i  in  1  lower level accepts the request.
drop_count_o  out  16  saturating count of dropped and squashed prefetches.
q_count_o  out  $clog2(QUEUE_DEPTH)+1  live plus dead entries currently queued.

Behaviour:
- Reset (rst low, asynchronous):
  - Outputs: lo_valid_o=0, lo_addr_o=0, lo_is_prefetch_o=0, drop_count_o=0, q_count_o=0, pf_ready_o=0, dm_ready_o=0.
  - Internal: queue pointers and entry valid bits cleared; starvation counter = 0; FSM = EMPTY.
  - Reset asserted mid-operation discards any held output and all queued entries.
  - After reset release: pf_ready_o=1.
- Queue:
  - pf_ready_o = (q_count_o < QUEUE_DEPTH), computed from registered count. A full queue does not accept a candidate even if it pops in the same cycle.
  - On pf_valid_i & pf_ready_o the block address (pf_addr_i with low BLOCK_OFFSET bits cleared) is checked.
  - The candidate is dropped (drop_count +1, saturating at 0xFFFF) if it matches any live queued entry, the held lo_addr_o block, or the demand block accepted in the same cycle. Otherwise it is pushed at the tail with live=1.
- Demand squash:
  - When a demand is accepted, every live queued entry with the same block is marked dead; drop_count increases by 1 per squashed entry (saturating).
  - A dead entry at the head is popped in one cycle without issue and without a grant.
- Output slot FSM; states EMPTY, HOLD_DM, HOLD_PF:
  - The slot is free when state=EMPTY or (lo_valid_o & lo_ready_i).
  - While the slot is not free, lo_* hold stable and dm_ready_o=0.
  - When the slot is free, the arbiter acts as follows:
    - If starve_cnt == STARVE_LIMIT and the head is live: grant the prefetch; dm_ready_o=0.
    - Else if dm_valid_i: dm_ready_o=1; load the demand (full unaligned address, is_prefetch=0) → HOLD_DM.
    - Else if the head is live: load the prefetch (is_prefetch=1) → HOLD_PF.
    - Else → EMPTY, lo_valid_o=0.
  - dm_ready_o is combinational from the slot-free condition, starvation state and head liveness.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each demand grant while a live head exists.
  - Clears on each prefetch grant, or when no live entry remains.
- Latency:
  - A demand accepted in cycle N appears on lo_* in cycle N+1.
  - A prefetch pushed in cycle N is eligible in cycle N+1 at the earliest and appears on lo_* in N+2.
- Simultaneous events:
  - Push and pop in the same cycle leave q_count_o unchanged.
  - A squash and a push of the same block in the same cycle: the push is dropped per the rule above.
- q_count_o counts dead entries until they are popped.

Test Plan:
- Reset check: drive rst low mid-HOLD_PF with 3 entries queued → lo_valid_o=0, q_count_o=0, drop_count_o=0 immediately; pf_ready_o=1 on the first cycle after release.
- Dedup: push 0x1000, then 0x1008, then 0x2000 with lo_ready_i=0 → queue holds 0x1000 and 0x2000; drop_count_o=1; after lo_ready_i=1 the prefetches issue in order 0x1000, 0x2000 with lo_is_prefetch_o=1.
- Priority and starvation: queue 0x3000; hold dm_valid_i=1 with addresses 0xA000, 0xA040, ... and lo_ready_i=1 → 4 demands issue, then 0x3000 with dm_ready_o=0 for that cycle, then demands resume.
- Squash: queue 0x4000 and 0x5000; accept a demand to 0x4010 → demand issues, the 0x4000 entry is popped without issue, drop_count_o increases by 1, and 0x5000 issues next.
- Full and backpressure: lo_ready_i=0; push 8 distinct blocks → pf_ready_o=0 with q_count_o=8; a 9th candidate held valid is not accepted and not counted; one pop re-enables pf_ready_o.
- Hold stability: with lo_valid_o=1 and lo_ready_i=0 for 5 cycles while dm and pf inputs toggle → lo_addr_o and lo_is_prefetch_o unchanged and dm_ready_o=0 throughout.
